// File: rtl/axi_slave_mux_r.sv
// rtl/axi_slave_mux_r.sv - AXI read-channel 1:2 slave mux, one outstanding transaction.
// Optional AXI_MUX_R_DECERR_EN: ARADDR[31:30]=2'b11 is unmapped and answered with DECERR beats.
module axi_slave_mux_r #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] s_ARADDR,
  input  logic [ID_WIDTH-1:0]   s_ARID,
  input  logic [7:0]            s_ARLEN,
  input  logic                  s_ARVALID,
  input  logic                  s_RREADY,
  output logic                  m_ARREADY,
  output logic [ID_WIDTH-1:0]   m_RID,
  output logic [DATA_WIDTH-1:0] m_RDATA,
  output logic [1:0]            m_RRESP,
  output logic [USER_WIDTH-1:0] m_RUSER,
  output logic                  m_RLAST,
  output logic                  m_RVALID,
  output logic                  s0_ARVALID,
  output logic                  s0_RREADY,
  input  logic                  s0_ARREADY,
  input  logic [ID_WIDTH-1:0]   s0_RID,
  input  logic [DATA_WIDTH-1:0] s0_RDATA,
  input  logic [1:0]            s0_RRESP,
  input  logic [USER_WIDTH-1:0] s0_RUSER,
  input  logic                  s0_RLAST,
  input  logic                  s0_RVALID,
  output logic                  s1_ARVALID,
  output logic                  s1_RREADY,
  input  logic                  s1_ARREADY,
  input  logic [ID_WIDTH-1:0]   s1_RID,
  input  logic [DATA_WIDTH-1:0] s1_RDATA,
  input  logic [1:0]            s1_RRESP,
  input  logic [USER_WIDTH-1:0] s1_RUSER,
  input  logic                  s1_RLAST,
  input  logic                  s1_RVALID
);

`ifdef AXI_MUX_R_DECERR_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

  state_t              state_q, state_d;
  logic                sel_q;
  logic [ID_WIDTH-1:0] arid_q;
  logic [7:0]          arlen_q;
  logic                ar_ready;
  logic                r_valid;
  logic                r_last;

  // Only ARADDR[31] (and [30] with decode errors) routes; the rest is consumed here.
  logic unused_addr;
  assign unused_addr = ^s_ARADDR;

`ifdef AXI_MUX_R_DECERR_EN
  logic       unmapped_q;
  logic [7:0] beat_q;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      arid_q  <= '0;
      arlen_q <= '0;
`ifdef AXI_MUX_R_DECERR_EN
      unmapped_q <= 1'b0;
      beat_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && s_ARVALID) begin
        sel_q   <= s_ARADDR[31];
        arid_q  <= s_ARID;
        arlen_q <= s_ARLEN;
`ifdef AXI_MUX_R_DECERR_EN
        unmapped_q <= &s_ARADDR[31:30];
`endif
      end
`ifdef AXI_MUX_R_DECERR_EN
      if (state_q == ERR && s_RREADY)
        beat_q <= (beat_q == arlen_q) ? 8'd0 : beat_q + 8'd1;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    r_last     = 1'b0;
    m_RID      = '0;
    m_RDATA    = '0;
    m_RRESP    = 2'b00;
    m_RUSER    = '0;
    s0_ARVALID = 1'b0;
    s1_ARVALID = 1'b0;
    s0_RREADY  = 1'b0;
    s1_RREADY  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_ARVALID) state_d = ADDR;
      end
      ADDR: begin
`ifdef AXI_MUX_R_DECERR_EN
        if (unmapped_q) begin
          ar_ready = 1'b1;
          if (s_ARVALID) state_d = ERR;
        end else
`endif
        begin
          if (sel_q) begin
            s1_ARVALID = s_ARVALID;
            ar_ready   = s1_ARREADY;
          end else begin
            s0_ARVALID = s_ARVALID;
            ar_ready   = s0_ARREADY;
          end
          if (s_ARVALID && ar_ready) state_d = DATA;
        end
      end
      DATA: begin
        // The unselected slave's R channel is never looked at.
        if (sel_q) begin
          m_RID     = s1_RID;
          m_RDATA   = s1_RDATA;
          m_RRESP   = s1_RRESP;
          m_RUSER   = s1_RUSER;
          r_last    = s1_RLAST;
          r_valid   = s1_RVALID;
          s1_RREADY = s_RREADY;
        end else begin
          m_RID     = s0_RID;
          m_RDATA   = s0_RDATA;
          m_RRESP   = s0_RRESP;
          m_RUSER   = s0_RUSER;
          r_last    = s0_RLAST;
          r_valid   = s0_RVALID;
          s0_RREADY = s_RREADY;
        end
        if (r_valid && s_RREADY && r_last) state_d = IDLE;
      end
`ifdef AXI_MUX_R_DECERR_EN
      ERR: begin
        r_valid = 1'b1;
        m_RRESP = 2'b11;
        m_RID   = arid_q;
        r_last  = (beat_q == arlen_q);
        if (s_RREADY && r_last) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign m_ARREADY = ar_ready;
  assign m_RVALID  = r_valid;
  assign m_RLAST   = r_last;

endmodule

// File: tb/tb_axi_slave_mux_r.sv
// tb/tb_axi_slave_mux_r.sv - directed scoreboard bench for axi_slave_mux_r.
// Build with or without AXI_MUX_R_DECERR_EN; the unmapped-address step adapts.
module tb_axi_slave_mux_r;
  localparam int DW = 1024;
  localparam int AW = 64;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [AW-1:0] s_ARADDR;
  logic [7:0]    s_ARID, s_ARLEN;
  logic          s_ARVALID, s_RREADY;
  logic          m_ARREADY, m_RLAST, m_RVALID;
  logic [7:0]    m_RID, m_RUSER;
  logic [DW-1:0] m_RDATA;
  logic [1:0]    m_RRESP;
  logic          s0_ARVALID, s0_RREADY, s0_ARREADY, s0_RLAST, s0_RVALID;
  logic [7:0]    s0_RID, s0_RUSER;
  logic [DW-1:0] s0_RDATA;
  logic [1:0]    s0_RRESP;
  logic          s1_ARVALID, s1_RREADY, s1_ARREADY, s1_RLAST, s1_RVALID;
  logic [7:0]    s1_RID, s1_RUSER;
  logic [DW-1:0] s1_RDATA;
  logic [1:0]    s1_RRESP;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    id;
    logic [1:0]    resp;
    logic [7:0]    user;
    logic          last;
  } beat_t;
  beat_t sb[$];

  axi_slave_mux_r #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(8), .USER_WIDTH(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_ARADDR(s_ARADDR), .s_ARID(s_ARID), .s_ARLEN(s_ARLEN), .s_ARVALID(s_ARVALID),
    .s_RREADY(s_RREADY), .m_ARREADY(m_ARREADY), .m_RID(m_RID), .m_RDATA(m_RDATA),
    .m_RRESP(m_RRESP), .m_RUSER(m_RUSER), .m_RLAST(m_RLAST), .m_RVALID(m_RVALID),
    .s0_ARVALID(s0_ARVALID), .s0_RREADY(s0_RREADY), .s0_ARREADY(s0_ARREADY),
    .s0_RID(s0_RID), .s0_RDATA(s0_RDATA), .s0_RRESP(s0_RRESP), .s0_RUSER(s0_RUSER),
    .s0_RLAST(s0_RLAST), .s0_RVALID(s0_RVALID),
    .s1_ARVALID(s1_ARVALID), .s1_RREADY(s1_RREADY), .s1_ARREADY(s1_ARREADY),
    .s1_RID(s1_RID), .s1_RDATA(s1_RDATA), .s1_RRESP(s1_RRESP), .s1_RUSER(s1_RUSER),
    .s1_RLAST(s1_RLAST), .s1_RVALID(s1_RVALID)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [DW-1:0] mk_data(int v);
    logic [63:0] w;
    w = 64'hA5A5_0000_0000_0000 | 64'(v);
    return {16{w}};
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge ACLK);
  endtask

  task automatic drive_beat(bit slv, int v, logic [7:0] id, bit last, bit exp);
    beat_t b;
    b.data = mk_data(v);
    b.id   = id;
    b.resp = slv ? 2'b01 : 2'b00;
    b.user = v[7:0];
    b.last = last;
    if (slv) begin
      s1_RVALID = 1'b1; s1_RDATA = b.data; s1_RID = id;
      s1_RRESP = b.resp; s1_RUSER = b.user; s1_RLAST = last;
    end else begin
      s0_RVALID = 1'b1; s0_RDATA = b.data; s0_RID = id;
      s0_RRESP = b.resp; s0_RUSER = b.user; s0_RLAST = last;
    end
    if (exp) sb.push_back(b);
  endtask

  task automatic idle_checks(string tag);
    at_neg();
    check({tag, "_arready"}, m_ARREADY, 1'b0);
    check({tag, "_s0arvalid"}, s0_ARVALID, 1'b0);
    check({tag, "_s1arvalid"}, s1_ARVALID, 1'b0);
    check({tag, "_rvalid"}, m_RVALID, 1'b0);
    check({tag, "_rlast"}, m_RLAST, 1'b0);
    check({tag, "_s0rready"}, s0_RREADY, 1'b0);
    check({tag, "_s1rready"}, s1_RREADY, 1'b0);
    check({tag, "_rdata"}, m_RDATA, '0);
    check({tag, "_rid"}, m_RID, 8'h00);
  endtask

  // Scoreboard consumer: every completed R handshake must match the oldest expected beat.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1 && m_RVALID === 1'b1 && s_RREADY === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed rdata=%0h expected no beat", m_RDATA[63:0]);
      end
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", m_RDATA, e.data);
        check("beat_id", m_RID, e.id);
        check("beat_resp", m_RRESP, e.resp);
        check("beat_user", m_RUSER, e.user);
        check("beat_last", m_RLAST, e.last);
      end
    end
  end

  initial begin
    ARESETn = 1'b0;
    s_ARADDR = '0; s_ARID = '0; s_ARLEN = '0; s_ARVALID = 1'b0; s_RREADY = 1'b0;
    s0_ARREADY = 1'b0; s0_RID = '0; s0_RDATA = '0; s0_RRESP = '0; s0_RUSER = '0;
    s0_RLAST = 1'b0; s0_RVALID = 1'b0;
    s1_ARREADY = 1'b0; s1_RID = '0; s1_RDATA = '0; s1_RRESP = '0; s1_RUSER = '0;
    s1_RLAST = 1'b0; s1_RVALID = 1'b0;
    repeat (3) step();
    ARESETn = 1'b1;
    s_RREADY = 1'b1;
    s0_RVALID = 1'b1; s0_RDATA = mk_data(99);
    idle_checks("reset");
    s0_RVALID = 1'b0;

    // Slave 0, ARLEN=3, ARREADY after two cycles in ADDR; slave 1 noise ignored.
    step();
    s_ARADDR = 64'h0000_1000; s_ARID = 8'h11; s_ARLEN = 8'd3; s_ARVALID = 1'b1;
    s1_RVALID = 1'b1; s1_RDATA = mk_data(77);
    step();
    at_neg();
    check("s1_s0arvalid", s0_ARVALID, 1'b1);
    check("s1_s1arvalid", s1_ARVALID, 1'b0);
    check("s1_arready_wait0", m_ARREADY, 1'b0);
    check("s1_addr_s0rready", s0_RREADY, 1'b0);
    step();
    at_neg();
    check("s1_arready_wait1", m_ARREADY, 1'b0);
    step();
    s0_ARREADY = 1'b1;
    at_neg();
    check("s1_arready", m_ARREADY, 1'b1);
    step();
    s_ARVALID = 1'b0; s0_ARREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b0, 10 + i, 8'h11, i == 3, 1'b1);
      at_neg();
      check("s1_s1rready", s1_RREADY, 1'b0);
      check("s1_s0rready", s0_RREADY, 1'b1);
      step();
    end
    s0_RVALID = 1'b0; s1_RVALID = 1'b0;
    idle_checks("s1_end");

    // Slave 1, ARLEN=0, master stalls three cycles; slave 0 RVALID must not leak.
    step();
    s_RREADY = 1'b0;
    s_ARADDR = 64'h8000_0000; s_ARID = 8'h22; s_ARLEN = 8'd0; s_ARVALID = 1'b1;
    s1_ARREADY = 1'b1;
    step();
    at_neg();
    check("s2_arready", m_ARREADY, 1'b1);
    check("s2_s1arvalid", s1_ARVALID, 1'b1);
    check("s2_s0arvalid", s0_ARVALID, 1'b0);
    step();
    s_ARVALID = 1'b0; s1_ARREADY = 1'b0;
    drive_beat(1'b1, 20, 8'h22, 1'b1, 1'b0);
    s0_RVALID = 1'b1; s0_RDATA = mk_data(55); s0_RLAST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("s2_hold_rvalid", m_RVALID, 1'b1);
      check("s2_hold_rdata", m_RDATA, mk_data(20));
      check("s2_hold_rid", m_RID, 8'h22);
      check("s2_hold_s1rready", s1_RREADY, 1'b0);
      step();
    end
    drive_beat(1'b1, 20, 8'h22, 1'b1, 1'b1);
    s_RREADY = 1'b1;
    step();
    s1_RVALID = 1'b0;
    idle_checks("s2_end");
    s0_RVALID = 1'b0;

    // Back-to-back: ARVALID held through DATA, second AR only after returning to IDLE.
    step();
    s0_ARREADY = 1'b1;
    s_ARADDR = 64'h0000_2000; s_ARID = 8'h33; s_ARLEN = 8'd1; s_ARVALID = 1'b1;
    step();
    at_neg();
    check("s3_arready", m_ARREADY, 1'b1);
    step();
    at_neg();
    check("s3_held_arready", m_ARREADY, 1'b0);
    check("s3_held_s0arvalid", s0_ARVALID, 1'b0);
    step();
    drive_beat(1'b0, 30, 8'h33, 1'b0, 1'b1);
    step();
    drive_beat(1'b0, 31, 8'h33, 1'b1, 1'b1);
    step();
    at_neg();
    check("s3_gap_arready", m_ARREADY, 1'b0);
    check("s3_gap_s0arvalid", s0_ARVALID, 1'b0);
    check("s3_gap_rvalid", m_RVALID, 1'b0);
    step();
    at_neg();
    check("s3_accept2", m_ARREADY, 1'b1);
    step();
    s_ARVALID = 1'b0;
    drive_beat(1'b0, 32, 8'h33, 1'b0, 1'b1);
    step();
    drive_beat(1'b0, 33, 8'h33, 1'b1, 1'b1);
    step();
    s0_RVALID = 1'b0;
    idle_checks("s3_end");

    // Reset pulse on beat 2 of ARLEN=7, then a clean AR to slave 1.
    step();
    s_ARADDR = 64'h0000_3000; s_ARID = 8'h44; s_ARLEN = 8'd7; s_ARVALID = 1'b1;
    step();
    step();
    s_ARVALID = 1'b0;
    drive_beat(1'b0, 40, 8'h44, 1'b0, 1'b1);
    step();
    drive_beat(1'b0, 41, 8'h44, 1'b0, 1'b1);
    step();
    drive_beat(1'b0, 42, 8'h44, 1'b0, 1'b0);
    #2;
    ARESETn = 1'b0;
    at_neg();
    check("s4_rst_rvalid", m_RVALID, 1'b0);
    check("s4_rst_s0rready", s0_RREADY, 1'b0);
    check("s4_rst_arready", m_ARREADY, 1'b0);
    check("s4_rst_s0arvalid", s0_ARVALID, 1'b0);
    check("s4_rst_s1arvalid", s1_ARVALID, 1'b0);
    step();
    ARESETn = 1'b1; s0_RVALID = 1'b0; s0_ARREADY = 1'b0;
    s_ARADDR = 64'h8000_0100; s_ARID = 8'h45; s_ARLEN = 8'd0; s_ARVALID = 1'b1;
    s1_ARREADY = 1'b1;
    step();
    at_neg();
    check("s4_next_s1arvalid", s1_ARVALID, 1'b1);
    check("s4_next_s0arvalid", s0_ARVALID, 1'b0);
    step();
    s_ARVALID = 1'b0; s1_ARREADY = 1'b0;
    drive_beat(1'b1, 50, 8'h45, 1'b1, 1'b1);
    step();
    s1_RVALID = 1'b0;
    idle_checks("s4_end");

    // ARADDR[31:30]=2'b11: decode error when enabled, plain slave-1 route otherwise.
    step();
    s_ARADDR = 64'hC000_0000; s_ARID = 8'h5A; s_ARLEN = 8'd2; s_ARVALID = 1'b1;
`ifdef AXI_MUX_R_DECERR_EN
    step();
    at_neg();
    check("s5_arready", m_ARREADY, 1'b1);
    check("s5_s0arvalid", s0_ARVALID, 1'b0);
    check("s5_s1arvalid", s1_ARVALID, 1'b0);
    step();
    s_ARVALID = 1'b0; s_RREADY = 1'b0;
    at_neg();
    check("s5_stall_rvalid", m_RVALID, 1'b1);
    check("s5_stall_rresp", m_RRESP, 2'b11);
    check("s5_stall_rlast", m_RLAST, 1'b0);
    step();
    at_neg();
    check("s5_stall2_rlast", m_RLAST, 1'b0);
    step();
    s_RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat_t b;
      b.data = '0; b.id = 8'h5A; b.resp = 2'b11; b.user = 8'h00; b.last = (i == 2);
      sb.push_back(b);
    end
    repeat (3) step();
    idle_checks("s5_end");
`else
    s1_ARREADY = 1'b1;
    step();
    at_neg();
    check("s5_s1arvalid", s1_ARVALID, 1'b1);
    check("s5_s0arvalid", s0_ARVALID, 1'b0);
    step();
    s_ARVALID = 1'b0; s1_ARREADY = 1'b0;
    drive_beat(1'b1, 60, 8'h5A, 1'b1, 1'b1);
    step();
    s1_RVALID = 1'b0;
    idle_checks("s5_end");
`endif

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_slave_mux_r.md
AXI_SLAVE_MUX_R -- requirements
Module: axi_slave_mux_r

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1024, meaning the read data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 64, meaning the read address width (≥32).
REQ-003 The block SHALL have parameter ID_WIDTH, default 8, meaning the ID width.
REQ-004 The block SHALL have parameter USER_WIDTH, default 8, meaning the RUSER width.
REQ-005 The block SHALL have port ACLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port ARESETn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have master-side inputs, one per line:
- s_ARADDR, ADDR_WIDTH: read address.
- s_ARID, ID_WIDTH: read ID.
- s_ARLEN, 8: beat count minus one.
- s_ARVALID, 1: address valid.
- s_RREADY, 1: data ready.
REQ-008 The block SHALL have master-side outputs, one per line:
- m_ARREADY, 1: address ready.
- m_RID, ID_WIDTH: response ID.
- m_RDATA, DATA_WIDTH: read data.
- m_RRESP, 2: response code.
- m_RUSER, USER_WIDTH: user sideband.
- m_RLAST, 1: last beat.
- m_RVALID, 1: data valid.
REQ-009 For each slave n in {0,1}, the block SHALL have:
- Outputs, 1 bit each: sn_ARVALID, sn_RREADY.
- Inputs: sn_ARREADY (1), sn_RID (ID_WIDTH), sn_RDATA (DATA_WIDTH), sn_RRESP (2), sn_RUSER (USER_WIDTH), sn_RLAST (1), sn_RVALID (1).

Function
REQ-010 The block SHALL implement FSM states IDLE, ADDR, DATA, plus ERR when the configuration macro is defined.
REQ-011 In IDLE with s_ARVALID=1, the block SHALL latch sel=s_ARADDR[31], ARID and ARLEN, then enter ADDR on the next cycle.
REQ-012 In ADDR, the block SHALL drive s<sel>_ARVALID=s_ARVALID and m_ARREADY=s<sel>_ARREADY.
REQ-013 In ADDR, the block SHALL drive the other slave's ARVALID to 0.
REQ-014 In ADDR, on ARVALID&ARREADY the block SHALL enter DATA.
REQ-015 Outside ADDR, m_ARREADY and both sn_ARVALID SHALL be 0; address latency is therefore at least 1 cycle.
REQ-016 In DATA, the R-channel outputs (m_RID/RDATA/RRESP/RUSER/RLAST/RVALID) SHALL combinationally mirror slave sel, with s<sel>_RREADY=s_RREADY.
REQ-017 In DATA, the unselected slave's RREADY SHALL be 0.
REQ-018 In DATA, on m_RVALID&s_RREADY&m_RLAST the block SHALL return to IDLE; a new address is accepted no earlier than the following cycle.
REQ-019 Outside DATA/ERR, m_RVALID, m_RLAST and both sn_RREADY SHALL be 0, and m_RID/RDATA/RRESP/RUSER SHALL be 0.
REQ-020 The block SHALL allow exactly one outstanding transaction; s_ARVALID held during ADDR/DATA SHALL be ignored until IDLE.
REQ-021 Unselected-slave RVALID SHALL be ignored and never propagate.
REQ-022 RVALID with RREADY=0 SHALL hold state and hold the mirrored outputs unchanged.

Reset
REQ-023 ARESETn low SHALL asynchronously force IDLE and clear sel, ARID, ARLEN and the beat counter to 0.
REQ-024 During reset, all valid/ready outputs SHALL be 0, including mid-transaction; no beat completes and no slave is notified.

Configuration
REQ-025 With macro AXI_MUX_R_DECERR_EN defined, an address with s_ARADDR[31:30]=2'b11 SHALL be unmapped.
REQ-026 For an unmapped address in ADDR, the block SHALL assert m_ARREADY=1 itself, keep both sn_ARVALID=0, and enter ERR.
REQ-027 In ERR, the block SHALL return ARLEN+1 beats with RVALID=1, RDATA=0, RUSER=0, RRESP=2'b11, RID=latched ARID, and RLAST on the final beat.
REQ-028 In ERR, an 8-bit beat counter SHALL advance only on s_RREADY=1, and the block SHALL return to IDLE after the last beat.
REQ-029 Without AXI_MUX_R_DECERR_EN, routing SHALL use ARADDR[31] only, and no ERR state or counter SHALL exist.

Verification
REQ-030 The bench SHALL cover: ARADDR=0x0000_1000, ARLEN=3, s0 ARREADY after 2 cycles -> only s0_ARVALID asserted, 4 beats routed from s0, return to IDLE after RLAST.
REQ-031 The bench SHALL cover: ARADDR=0x8000_0000, ARLEN=0, s_RREADY low for 3 cycles -> m_RDATA held, s1_RREADY=0 until RREADY, one beat, then IDLE.
REQ-032 The bench SHALL cover: back-to-back AR with s_ARVALID held through DATA -> second address accepted ≥1 cycle after first RLAST handshake.
REQ-033 The bench SHALL cover: s0_RVALID asserted while sel=1 -> m_RVALID stays 0.
REQ-034 The bench SHALL cover: ARESETn pulsed low on beat 2 of ARLEN=7 -> immediate IDLE, all valids 0, next AR routes cleanly.
REQ-035 The bench SHALL cover, with AXI_MUX_R_DECERR_EN: ARADDR=0xC000_0000, ARID=0x5A, ARLEN=2 -> no slave ARVALID; 3 beats RRESP=2'b11, RID=0x5A, RLAST on beat 3.
